// File: rtl/ad_trigger_capture.sv
// Trigger-aligned capture controller: keeps a circular DEPTH-sample record around a level crossing.
// Writes appear one cycle after the sample; frame_valid, rd_base and trig_seen update with the last frame write.
module ad_trigger_capture #(
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 128,
  parameter int AUTO_TIMEOUT = 6000000,
  parameter int HOLDOFF      = 6000000
) (
  input  logic              ad_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        ad_data,
  input  logic [7:0]        trig_level,
  input  logic              trig_edge,
  input  logic              trig_mode,
  output logic [7:0]        buf_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_wren,
  output logic [ADDR_W-1:0] rd_base,
  output logic              frame_valid,
  output logic              trig_seen
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF - 1);
  localparam logic [HO_W-1:0]   HO_ONE    = HO_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wp;
  logic [7:0]        r_d1;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [HO_W-1:0]   r_hold_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_trig_src;

  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_timeout;
  logic w_write;

  always_comb begin
    w_rise    = (r_d1 < trig_level) && (ad_data >= trig_level);
    w_fall    = (r_d1 > trig_level) && (ad_data <= trig_level);
    w_edge    = trig_edge ? w_fall : w_rise;
    w_timeout = !trig_mode && (r_to_cnt == TO_LAST);
    w_write   = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  end

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_wp        <= '0;
      r_d1        <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_to_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_trig_addr <= '0;
      r_trig_src  <= 1'b0;
      buf_data    <= '0;
      buf_addr    <= '0;
      buf_wren    <= 1'b0;
      rd_base     <= '0;
      frame_valid <= 1'b0;
      trig_seen   <= 1'b0;
    end else begin
      r_d1        <= ad_data;
      buf_data    <= ad_data;
      buf_addr    <= r_wp;
      buf_wren    <= w_write;
      frame_valid <= 1'b0;
      if (w_write) r_wp <= r_wp + A_ONE;

      case (r_state)
        S_IDLE: begin
          r_state   <= S_PRE;
          r_pre_cnt <= '0;
        end
        S_PRE: begin
          if (r_pre_cnt == PRE_LAST) begin
            r_state  <= S_ARMED;
            r_to_cnt <= '0;
          end else begin
            r_pre_cnt <= r_pre_cnt + A_ONE;
          end
        end
        S_ARMED: begin
          // Edge takes priority over timeout; the timer saturates so a switch to auto fires promptly.
          if (w_edge || w_timeout) begin
            r_trig_src  <= w_edge;
            r_trig_addr <= r_wp;
            r_post_cnt  <= '0;
            r_state     <= S_POST;
          end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        S_POST: begin
          if (r_post_cnt == POST_LAST) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            frame_valid <= 1'b1;
            rd_base     <= r_trig_addr - PRE_OFS;
            trig_seen   <= r_trig_src;
          end else begin
            r_post_cnt <= r_post_cnt + A_ONE;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HO_LAST) begin
            r_state   <= S_PRE;
            r_pre_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HO_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_trigger_capture.sv
// Bench for ad_trigger_capture with DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=20, HOLDOFF=8, trig_level=0x80.
module tb_ad_trigger_capture;

  logic       ad_clk;
  logic       sys_rst_n;
  logic [7:0] ad_data;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic       trig_mode;
  logic [7:0] buf_data;
  logic [3:0] buf_addr;
  logic       buf_wren;
  logic [3:0] rd_base;
  logic       frame_valid;
  logic       trig_seen;

  ad_trigger_capture #(
    .ADDR_W(4), .PRE_TRIG(4), .AUTO_TIMEOUT(20), .HOLDOFF(8)
  ) dut (
    .ad_clk(ad_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
    .buf_data(buf_data), .buf_addr(buf_addr), .buf_wren(buf_wren),
    .rd_base(rd_base), .frame_valid(frame_valid), .trig_seen(trig_seen)
  );

  initial ad_clk = 1'b0;
  always #5 ad_clk = ~ad_clk;

  // Stream: v0 for cycles < b1, v1 until b2, v2 until b3, then v3. Cycle 0 is the IDLE cycle.
  typedef struct {
    logic       mode;
    logic       edg;
    logic [7:0] v0, v1, v2, v3;
    int         b1, b2, b3;
    int         k;
    logic [3:0] rb;
    logic       ts;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       fv;
    logic [3:0] rb;
    logic       ts;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic mode, input logic edg,
                              input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3,
                              input int b1, input int b2, input int b3,
                              input int k, input logic [3:0] rb, input logic ts);
    vec_t v;
    v.mode = mode; v.edg = edg;
    v.v0 = v0; v.v1 = v1; v.v2 = v2; v.v3 = v3;
    v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.k = k; v.rb = rb; v.ts = ts;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_buf_wren"}, buf_wren, 0);
    chk({tag, "_buf_addr"}, buf_addr, 0);
    chk({tag, "_buf_data"}, buf_data, 0);
    chk({tag, "_frame_valid"}, frame_valid, 0);
    chk({tag, "_rd_base"}, rd_base, 0);
    chk({tag, "_trig_seen"}, trig_seen, 0);
  endtask

  // Drive one sample, push what the DUT must write for it, then compare after the edge.
  task automatic cyc(input logic [7:0] d, input bit wr, input logic [3:0] addr,
                     input bit fv, input logic [3:0] rb, input logic ts);
    exp_t e;
    bit   have;
    ad_data = d;
    if (wr) begin
      e.addr = addr; e.data = d; e.fv = fv; e.rb = rb; e.ts = ts;
      sb_q.push_back(e);
    end
    @(posedge ad_clk);
    @(negedge ad_clk);
    have = (sb_q.size() > 0);
    chk("buf_wren", buf_wren, have);
    if (have) begin
      e = sb_q.pop_front();
      if (buf_wren) begin
        chk("buf_addr", buf_addr, e.addr);
        chk("buf_data", buf_data, e.data);
      end
      chk("frame_valid", frame_valid, e.fv);
      if (e.fv) begin
        chk("rd_base", rd_base, e.rb);
        chk("trig_seen", trig_seen, e.ts);
      end
    end else begin
      chk("frame_valid_idle", frame_valid, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge ad_clk);
    sys_rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_zero("reset");
    @(negedge ad_clk);
    sys_rst_n = 1'b1;
  endtask

  // Frame of k ARMED samples: writes at cycles 1..15+k, 8 hold cycles, then PRE resumes at rd_base.
  task automatic run_row(input vec_t v);
    logic [7:0] d;
    bit         wr;
    logic [3:0] addr;
    trig_mode = v.mode;
    trig_edge = v.edg;
    for (int c = 0; c <= 27 + v.k; c++) begin
      if (c < v.b1)      d = v.v0;
      else if (c < v.b2) d = v.v1;
      else if (c < v.b3) d = v.v2;
      else               d = v.v3;
      wr   = (c >= 1 && c <= 15 + v.k) || (c >= 24 + v.k);
      addr = (c <= 15 + v.k) ? 4'(c - 1) : 4'(c - 9);
      cyc(d, wr, addr, (c == 15 + v.k), v.rb, v.ts);
      if (c == 23 + v.k) begin
        chk("rd_base_hold", rd_base, v.rb);
        chk("trig_seen_hold", trig_seen, v.ts);
      end
    end
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    ad_data    = 8'h00;
    trig_level = 8'h80;
    trig_edge  = 1'b0;
    trig_mode  = 1'b1;

    //         mode  edg   v0     v1     v2     v3     b1    b2    b3    k   rb     ts
    tbl[0] = mk(1'b1, 1'b0, 8'h10, 8'h90, 8'h90, 8'h90, 7,    1000, 1000, 3,  4'd2, 1'b1);
    tbl[1] = mk(1'b0, 1'b0, 8'h10, 8'h10, 8'h10, 8'h10, 1000, 1000, 1000, 20, 4'd3, 1'b0);
    tbl[2] = mk(1'b1, 1'b1, 8'hF0, 8'h80, 8'h80, 8'h80, 5,    1000, 1000, 1,  4'd0, 1'b1);
    tbl[3] = mk(1'b1, 1'b0, 8'h10, 8'h90, 8'h10, 8'h90, 4,    6,    7,    3,  4'd2, 1'b1);
    tbl[4] = mk(1'b0, 1'b0, 8'h10, 8'h90, 8'h90, 8'h90, 24,   1000, 1000, 20, 4'd3, 1'b1);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      run_row(tbl[r]);
    end

    // Normal mode with no crossing: continuous overwrite, no frame.
    do_reset();
    trig_mode = 1'b1;
    trig_edge = 1'b0;
    for (int c = 0; c < 200; c++) cyc(8'h10, (c >= 1), 4'(c - 1), 1'b0, 4'd0, 1'b0);
    chk("noedge_rd_base", rd_base, 0);
    chk("noedge_trig_seen", trig_seen, 0);

    // Reset in the middle of POST discards the frame; the next one starts at address 0.
    do_reset();
    trig_mode = 1'b1;
    trig_edge = 1'b0;
    for (int c = 0; c <= 12; c++) cyc((c < 7) ? 8'h10 : 8'h90, (c >= 1), 4'(c - 1), 1'b0, 4'd0, 1'b0);
    @(posedge ad_clk);
    #2 sys_rst_n = 1'b0;
    #1 chk_zero("midpost");
    sb_q.delete();
    @(negedge ad_clk);
    @(negedge ad_clk);
    chk_zero("midpost_held");
    sys_rst_n = 1'b1;
    run_row(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_trigger_capture.md
Name: ad_trigger_capture

Overview:
- Acquisition controller between the 8-bit AD input and the dual-clock capture RAM write port, in the ad_clk domain.
- Stores a circular record of DEPTH samples around a level-crossing trigger, with PRE_TRIG samples kept before the trigger.
- Tells the display read side where the oldest sample of the last completed frame sits, so the waveform is drawn trigger-aligned.
- Supports auto and normal trigger modes, rising or falling edge, and a holdoff between frames.

Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W samples per frame.
- PRE_TRIG, 128, number of samples stored before the trigger sample; range 1..DEPTH-2.
- AUTO_TIMEOUT, 6000000, ARMED cycles before a forced trigger in auto mode; must be >= 1.
- HOLDOFF, 6000000, idle cycles after a frame completes before re-arming; must be >= 1.

Ports:
- ad_clk  in  1  AD sample clock; the single clock of the block.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- ad_data  in  8  unsigned AD sample, valid every ad_clk.
- trig_level  in  8  unsigned trigger threshold.
- trig_edge  in  1  trigger slope: 0 = rising, 1 = falling.
- trig_mode  in  1  trigger mode: 0 = auto, 1 = normal.
- buf_data  out  8  RAM write data.
- buf_addr  out  ADDR_W  RAM write address.
- buf_wren  out  1  RAM write enable.
- rd_base  out  ADDR_W  address of the oldest sample of the last completed frame.
- frame_valid  out  1  one-cycle pulse when a frame completes.
- trig_seen  out  1  1 if the last completed frame came from a real edge, 0 if it was forced.

Behaviour:
- Reset, asynchronous:
  - All outputs go to 0.
  - State = IDLE; write pointer wp = 0; all counters = 0; d1 = 0.
  - Reset asserted mid-frame discards the frame with no frame_valid.
- Registered outputs: a sample that is written at input cycle n appears on buf_data, buf_addr and buf_wren at cycle n+1.
  - buf_addr = wp at write time.
  - wp increments modulo DEPTH after every write and is never cleared between frames.
- d1 holds the previous cycle's ad_data.
- Edge condition, evaluated against the current ad_data:
  - Rising: d1 < trig_level and ad_data >= trig_level.
  - Falling: d1 > trig_level and ad_data <= trig_level.
  - trig_level is compared live every cycle and is not latched.
- States:
  - IDLE: no write. Next cycle goes to PRE, with pre_cnt = 0.
  - PRE: write every cycle and increment pre_cnt. Edges are ignored. On the write where pre_cnt == PRE_TRIG-1, go to ARMED with to_cnt = 0.
  - ARMED: write every cycle.
    - If the edge condition holds, the current sample is the trigger sample and trig_src = 1.
    - Else if trig_mode == 0 and to_cnt == AUTO_TIMEOUT-1, the current sample is the trigger sample and trig_src = 0.
    - Else increment to_cnt.
    - On a trigger: trig_addr = wp, post_cnt = 0, go to POST.
    - In normal mode with no edge, the block stays in ARMED forever and overwrites the buffer continuously.
  - POST: write every cycle. On the write where post_cnt == DEPTH-PRE_TRIG-2, go to HOLD; otherwise increment post_cnt.
    - Output on that last write, in the same cycle as the last write's buf outputs:
      - frame_valid = 1.
      - rd_base = (trig_addr - PRE_TRIG) mod DEPTH.
      - trig_seen = trig_src.
  - HOLD: no writes (buf_wren = 0). Stay exactly HOLDOFF cycles, then go to PRE with pre_cnt = 0.
- Frame layout: PRE_TRIG samples, then the trigger sample, then DEPTH-PRE_TRIG-1 samples. These occupy DEPTH contiguous addresses (modulo DEPTH) starting at rd_base.
- rd_base and trig_seen hold their value until the next frame_valid.
- trig_mode and trig_edge changes take effect on the next ARMED cycle. There are no glitches and no partial frames.
- Simultaneous edge and timeout: the edge wins and trig_seen = 1.

Test Plan:
All scenarios use ADDR_W=4 (DEPTH=16), PRE_TRIG=4, AUTO_TIMEOUT=20, HOLDOFF=8 and trig_level=0x80.
1. Rising trigger: mode normal, edge rising; ad_data = 0x10, switching to 0x90 on the 3rd ARMED sample. Required response:
   - PRE writes addresses 0..3 and the trigger lands at address 6.
   - frame_valid pulses together with buf_addr = 1, with rd_base = 2 and trig_seen = 1.
   - buf_wren is low for exactly 8 cycles, then writes resume at address 2.
2. Auto trigger: mode auto, ad_data held at 0x10. Required response:
   - The 20th ARMED sample (address 7) is the forced trigger.
   - frame_valid pulses with rd_base = 3 and trig_seen = 0.
3. Normal mode, no edge: ad_data held at 0x10 for 200 cycles. Required response:
   - No frame_valid pulse.
   - buf_wren stays high after the IDLE cycle.
   - buf_addr wraps 15 -> 0.
   - rd_base stays 0.
4. Falling trigger: edge falling; ad_data = 0xF0, dropping to 0x80 on the 1st ARMED sample. Required response: trigger at address 4, rd_base = 0, trig_seen = 1. This also checks the equality boundary (ad_data == trig_level).
5. Edge during PRE: an edge inside PRE is ignored. Required response: the trigger occurs only at the next qualifying crossing in ARMED.
6. Reset mid-POST: assert sys_rst_n low for 1 cycle during POST. Required response:
   - Outputs go to 0 immediately and no frame_valid is issued.
   - The next frame starts writing at address 0.
   - Edge and timeout in the same cycle (auto mode) gives trig_seen = 1.
